mem_access_unit: RTL

Memory-access (MEM) stage of the 5-stage RISC-V pipeline, sitting between the EX/MEM pipeline register and the MEM/WB register. It turns load/store instructions into transactions on a valid/ready data-memory port and performs RV32I byte/halfword lane steering with sign/zero extension. It stalls the upstream pipeline until each access completes, and presents the results on the `me_*` bus that MEM/WB captures.

---
 rtl/mem_pkg.sv | 44 ++++
 rtl/mem_load_ext.sv | 27 ++
 rtl/mem_access_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: funct3 codes, FSM states, store lane helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  // size = funct3[1:0]: 00 byte, 01 half, anything else handled as a word
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = addr_lo[0];
      default: is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

  // Byte enables for a store of the given size at the given byte offset
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'b00:   store_be = 4'b0001 << addr_lo;
      2'b01:   store_be = 4'b0011 << addr_lo;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane so the byte enables pick the right one
  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] rs2);
    case (size)
      2'b00:   store_wdata = {4{rs2[7:0]}};
      2'b01:   store_wdata = {2{rs2[15:0]}};
      default: store_wdata = rs2;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load lane selection with sign/zero extension for RV32I loads.
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half and extend according to funct3
  always_comb begin
    byte_sel = 8'(rdata >> {addr_lo, 3'b000});
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (func3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h000000, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0000, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues load/store on a valid/ready data port, stalls
// upstream until the access completes, and forwards results to MEM/WB.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_alu_o,
  input  logic [31:0] ex_rs2_data,
  input  logic [4:0]  ex_rd,
  input  logic [2:0]  ex_func3,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_mem2reg,
  input  logic        ex_regs_write,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_misalign,
  output logic        mem_fault,
  output logic [31:0] me_mem_data,
  output logic [31:0] me_alu_o,
  output logic [4:0]  me_rd,
  output logic        me_mem2reg,
  output logic        me_regs_write
);

  localparam int unsigned CW = $clog2(RSP_TIMEOUT + 1);

  mem_state_t    state, state_d;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;
  logic          fault, fault_d;
  logic [31:0]   data, data_d;
  logic [31:0]   load_val;
  logic          op, is_store, misaligned;

  assign op         = ex_mem_read | ex_mem_write;
  assign is_store   = ex_mem_write;
  assign misaligned = is_misaligned(ex_func3[1:0], ex_alu_o[1:0]);
  assign cnt_inc    = cnt + CW'(1);

  // Request fields come straight from EX/MEM, which the stall holds stable
  assign dmem_addr  = {ex_alu_o[31:2], 2'b00};
  assign dmem_we    = is_store;
  assign dmem_be    = is_store ? store_be(ex_func3[1:0], ex_alu_o[1:0]) : 4'b1111;
  assign dmem_wdata = store_wdata(ex_func3[1:0], ex_rs2_data);

  assign mem_misalign  = op & misaligned;
  assign mem_fault     = (state == DONE) & fault;
  assign me_mem_data   = data;
  assign me_alu_o      = ex_alu_o;
  assign me_rd         = ex_rd;
  assign me_mem2reg    = ex_mem2reg;
  assign me_regs_write = ex_regs_write & ~mem_misalign & ~mem_fault;

  mem_load_ext u_load_ext (
    .rdata   (dmem_rdata),
    .addr_lo (ex_alu_o[1:0]),
    .func3   (ex_func3),
    .result  (load_val)
  );

  // State, timeout counter, fault flag and load data registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      fault <= 1'b0;
      data  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      fault <= fault_d;
      data  <= data_d;
    end
  end

  // Next-state and handshake/stall decode
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    fault_d        = fault;
    data_d         = data;
    dmem_req_valid = 1'b0;
    mem_stall      = 1'b0;
    case (state)
      IDLE: begin
        if (op && !misaligned) begin
          dmem_req_valid = 1'b1;
          mem_stall      = 1'b1;
          state_d        = dmem_req_ready ? WAIT : REQ;
        end
      end
      REQ: begin
        dmem_req_valid = 1'b1;
        mem_stall      = 1'b1;
        if (dmem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        mem_stall = 1'b1;
        cnt_d     = cnt_inc;
        if (dmem_rsp_valid) begin
          data_d  = is_store ? 32'h0 : load_val;
          state_d = DONE;
        end else if (cnt_inc == CW'(RSP_TIMEOUT)) begin
          data_d  = 32'h0;
          fault_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // data cleared so non-memory ops see zero on me_mem_data
        state_d = IDLE;
        cnt_d   = '0;
        fault_d = 1'b0;
        data_d  = 32'h0;
      end
      default: state_d = IDLE;
    endcase
    // Memory is in reset alongside us, so never present a request or stall then
    if (!rst) begin
      dmem_req_valid = 1'b0;
      mem_stall      = 1'b0;
    end
  end

endmodule
